// File: rtl/raizing_textrom_arbiter_if.sv
// raizing_textrom_arbiter_if: requester, priority and ROM-port signals of the text-ROM arbiter
//   PRIO_MODE            arbitration mode (0 round-robin, 1 requester 0 first)
//   REQn/ADDRn           read request and word address from requester n
//   GNTn/DATAn/DVALIDn   address accepted / returned word / return valid for requester n
//   ROM_ADDR/ROM_CS      registered ROM address and read strobe
//   ROM_DATA             ROM read data
interface raizing_textrom_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 16
);
    logic          PRIO_MODE;
    logic          REQ0, REQ1;
    logic [AW-1:0] ADDR0, ADDR1;
    logic          GNT0, GNT1;
    logic [DW-1:0] DATA0, DATA1;
    logic          DVALID0, DVALID1;
    logic [AW-1:0] ROM_ADDR;
    logic          ROM_CS;
    logic [DW-1:0] ROM_DATA;
    modport master (
        output PRIO_MODE, REQ0, ADDR0, REQ1, ADDR1, ROM_DATA,
        input  GNT0, DATA0, DVALID0, GNT1, DATA1, DVALID1, ROM_ADDR, ROM_CS
    );
    modport slave (
        input  PRIO_MODE, REQ0, ADDR0, REQ1, ADDR1, ROM_DATA,
        output GNT0, DATA0, DVALID0, GNT1, DATA1, DVALID1, ROM_ADDR, ROM_CS
    );
endinterface

// File: rtl/raizing_textrom_arbiter.sv
// raizing_textrom_arbiter: shares the text-ROM read port between the text layer (0) and extra-text renderer (1)
//   CLK96    video-domain clock, rising edge
//   RESET96  synchronous active-high reset
//   bus      requester handshakes, priority mode and ROM port (slave side)
module raizing_textrom_arbiter #(
    parameter int LAT = 2,
    parameter int AW  = 14,
    parameter int DW  = 16
) (
    input logic                   CLK96,
    input logic                   RESET96,
    raizing_textrom_arbiter_if.slave bus
);
    logic [1:0]            gnt_q, gnt_d, dv_q, dv_d;
    logic [AW-1:0]         rom_addr_q, rom_addr_d;
    logic                  rom_cs_q, rom_cs_d, gid_q, gid_d, last_q, last_d;
    logic [DW-1:0]         data0_q, data0_d, data1_q, data1_d;
    logic [LAT-1:0][1:0]   tag_q, tag_d;
    logic                  el0, el1, win1, any;

    // Tag = {valid, id}. The issue register (rom_cs_q/gid_q) is what the ROM
    // samples, so the tag rides there one cycle before entering the LAT-deep shift.
    generate
        for (genvar g = 0; g < LAT; g++) begin : g_tag
            if (g == 0) begin : g_head
                assign tag_d[g] = {rom_cs_q, gid_q};
            end else begin : g_body
                assign tag_d[g] = tag_q[g-1];
            end
        end
    endgenerate

    always_comb begin
        // A requester still holding REQ in its grant cycle is masked off.
        el0        = bus.REQ0 & ~gnt_q[0];
        el1        = bus.REQ1 & ~gnt_q[1];
        // last_q = 0 means requester 0 won most recently, so 1 takes the tie.
        win1       = el1 & (~el0 | (~bus.PRIO_MODE & ~last_q));
        any        = el0 | el1;
        gnt_d      = {win1, any & ~win1};
        rom_cs_d   = any;
        rom_addr_d = any ? (win1 ? bus.ADDR1 : bus.ADDR0) : rom_addr_q;
        gid_d      = win1;
        last_d     = any ? win1 : last_q;
        dv_d       = {tag_q[LAT-1][1] & tag_q[LAT-1][0], tag_q[LAT-1][1] & ~tag_q[LAT-1][0]};
        data0_d    = dv_d[0] ? bus.ROM_DATA : data0_q;
        data1_d    = dv_d[1] ? bus.ROM_DATA : data1_q;
    end

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            gnt_q      <= '0;
            dv_q       <= '0;
            rom_addr_q <= '0;
            rom_cs_q   <= 1'b0;
            gid_q      <= 1'b0;
            last_q     <= 1'b1;
            data0_q    <= '0;
            data1_q    <= '0;
            tag_q      <= '0;
        end else begin
            gnt_q      <= gnt_d;
            dv_q       <= dv_d;
            rom_addr_q <= rom_addr_d;
            rom_cs_q   <= rom_cs_d;
            gid_q      <= gid_d;
            last_q     <= last_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            tag_q      <= tag_d;
        end
    end

    assign bus.GNT0     = gnt_q[0];
    assign bus.GNT1     = gnt_q[1];
    assign bus.DVALID0  = dv_q[0];
    assign bus.DVALID1  = dv_q[1];
    assign bus.DATA0    = data0_q;
    assign bus.DATA1    = data1_q;
    assign bus.ROM_ADDR = rom_addr_q;
    assign bus.ROM_CS   = rom_cs_q;
endmodule

// File: tb/tb_raizing_textrom_arbiter.sv
// tb_raizing_textrom_arbiter: directed and randomized checks of the text-ROM arbiter against a queue-based model
module tb_raizing_textrom_arbiter;
    localparam int LAT = 2;
    typedef struct {
        int          due;
        int          id;
        logic [13:0] addr;
    } ret_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;
    int          n = 0;
    bit   [1:0]  m_gnt = '0;
    bit   [1:0]  m_dv = '0;
    bit          m_cs = 1'b0;
    logic [13:0] m_addr = '0;
    logic [15:0] m_data [2];
    int          m_last = 1;
    ret_t        pend [$];
    logic        hcs [8];
    logic [13:0] haddr [8];

    raizing_textrom_arbiter_if #(.AW(14), .DW(16)) bus ();

    raizing_textrom_arbiter #(.LAT(LAT), .AW(14), .DW(16)) dut (
        .CLK96   (clk),
        .RESET96 (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_fn(input logic [13:0] a);
        logic [31:0] t;
        t = (32'(a) * 32'h9E37) ^ 32'h5A5A;
        return (a == 14'h0123) ? 16'hBEEF : t[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, answer as the ROM, compare all outputs.
    task automatic step(input bit r, input bit p, input bit q0, input logic [13:0] a0,
                        input bit q1, input logic [13:0] a1);
        ret_t e;
        int   w;
        int   k;
        @(negedge clk);
        rst = r;
        bus.PRIO_MODE = p;
        bus.REQ0 = q0;
        bus.ADDR0 = a0;
        bus.REQ1 = q1;
        bus.ADDR1 = a1;
        @(posedge clk);
        n++;
        if (r) begin
            m_gnt = '0;
            m_dv = '0;
            m_cs = 1'b0;
            m_addr = '0;
            m_data[0] = '0;
            m_data[1] = '0;
            m_last = 1;
            pend.delete();
        end else begin
            m_dv = '0;
            if (pend.size() > 0 && pend[0].due == n) begin
                e = pend.pop_front();
                m_dv[e.id] = 1'b1;
                m_data[e.id] = rom_fn(e.addr);
            end
            w = -1;
            if (q0 && !m_gnt[0] && q1 && !m_gnt[1]) w = p ? 0 : 1 - m_last;
            else if (q0 && !m_gnt[0]) w = 0;
            else if (q1 && !m_gnt[1]) w = 1;
            m_gnt[0] = (w == 0);
            m_gnt[1] = (w == 1);
            m_cs = (w >= 0);
            if (w >= 0) begin
                m_addr = w ? a1 : a0;
                m_last = w;
                pend.push_back('{n + LAT + 1, w, m_addr});
            end
        end
        #1;
        hcs[n % 8] = bus.ROM_CS;
        haddr[n % 8] = bus.ROM_ADDR;
        k = n - LAT;
        bus.ROM_DATA = (k >= 0 && hcs[k % 8]) ? rom_fn(haddr[k % 8]) : 16'($urandom);
        chk("gnt0", bus.GNT0, m_gnt[0]);
        chk("gnt1", bus.GNT1, m_gnt[1]);
        chk("rom_cs", bus.ROM_CS, m_cs);
        chk("rom_addr", bus.ROM_ADDR, m_addr);
        chk("dvalid0", bus.DVALID0, m_dv[0]);
        chk("dvalid1", bus.DVALID1, m_dv[1]);
        chk("data0", bus.DATA0, m_data[0]);
        chk("data1", bus.DATA1, m_data[1]);
    endtask

    initial begin
        int          cnt;
        bit   [1:0]  outst;
        logic [13:0] ra [2];
        bit          p;
        m_data[0] = '0;
        m_data[1] = '0;
        bus.PRIO_MODE = 1'b0;
        bus.REQ0 = 1'b0;
        bus.REQ1 = 1'b0;
        bus.ADDR0 = '0;
        bus.ADDR1 = '0;
        bus.ROM_DATA = '0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0, 0);
            cnt += int'(bus.ROM_CS);
        end
        chk("idle_cs", cnt, 0);

        for (int i = 0; i < 4 && !bus.GNT0; i++) step(0, 0, 1, 14'h0123, 0, 0);
        chk("single_gnt", bus.GNT0, 1);
        chk("single_addr", {bus.ROM_CS, bus.ROM_ADDR}, {1'b1, 14'h0123});
        cnt = 0;
        for (int i = 0; i < 10 && !bus.DVALID0; i++) begin
            step(0, 0, 0, 0, 0, 0);
            cnt++;
        end
        chk("single_lat", cnt, 3);
        chk("single_data", bus.DATA0, 16'hBEEF);

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 14'h0010, 1, 14'h0020);
            chk("rr_order", {bus.GNT1, bus.GNT0}, (i % 2) ? 2 : 1);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 14'h0010, 1, 14'h0020);
            chk("fp_two", bus.GNT0 & bus.GNT1, 0);
            chk("fp_order", {bus.GNT1, bus.GNT0}, (i % 2) ? 2 : 1);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);

        step(0, 1, 1, 14'h0055, 1, 14'h0066);
        chk("abandon_win0", {bus.GNT1, bus.GNT0}, 1);
        step(0, 1, 1, 14'h0055, 0, 14'h0066);
        chk("mask_hold", {bus.GNT1, bus.GNT0}, 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0, 0);
            cnt += int'(bus.DVALID1) + int'(bus.GNT1);
        end
        chk("abandon_dv1", cnt, 0);

        for (int i = 0; i < 4 && !bus.GNT1; i++) step(0, 0, 0, 0, 1, 14'h0077);
        chk("mf_gnt1", bus.GNT1, 1);
        step(1, 0, 0, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0, 0);
            cnt += int'(bus.DVALID1);
        end
        chk("mf_dropped", cnt, 0);
        step(0, 0, 1, 14'h0100, 1, 14'h0200);
        chk("post_rst_tie", {bus.GNT1, bus.GNT0}, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0);

        outst = '0;
        ra[0] = '0;
        ra[1] = '0;
        p = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int j = 0; j < 2; j++) begin
                if (outst[j] && m_gnt[j]) outst[j] = 1'b0;
                if (outst[j] && $urandom_range(15) == 0) outst[j] = 1'b0;
                else if (!outst[j] && $urandom_range(2) != 0) begin
                    outst[j] = 1'b1;
                    ra[j] = 14'($urandom);
                end
            end
            if ($urandom_range(15) == 0) p = ~p;
            step($urandom_range(199) == 0, p, outst[0], ra[0], outst[1], ra[1]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
